// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB register, variable-latency load wait, load alignment and retire counting.
// Optional WB_BYPASS_EN adds wb_fwd_* outputs mirroring the register-file write port.
module writeback_stage #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             mem_valid,
   output logic             mem_ready,
   input  logic [4:0]       mem_rd,
   input  logic             mem_reg_wen,
   input  logic [1:0]       mem_wb_sel,
   input  logic [31:0]      mem_alu_result,
   input  logic [31:0]      mem_pc,
   input  logic [2:0]       mem_funct3,
   input  logic             dmem_rvalid,
   input  logic [31:0]      dmem_rdata,
   output logic [31:0]      wb_addr_rd,
   output logic [31:0]      wb_data_rd,
   output logic             wb_write_enable,
   output logic             wb_retire,
   output logic [CNT_W-1:0] wb_retire_count,
`ifdef WB_BYPASS_EN
   output logic             wb_fwd_valid,
   output logic [4:0]       wb_fwd_rd,
   output logic [31:0]      wb_fwd_data,
`endif
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_EMPTY     = 2'd0,
      ST_WAIT_LOAD = 2'd1,
      ST_FULL      = 2'd2
   } state_e;

   // Handshake: a transfer happens on a clock edge where mem_valid && mem_ready;
   // mem_ready depends only on registered state, never on mem_valid.

   state_e           state_q, state_d;
   logic [4:0]       rd_q, rd_d;
   logic             reg_wen_q, reg_wen_d;
   logic [31:0]      data_q, data_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [1:0]       ofs_q, ofs_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             accept;
   logic             is_full;

   function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] ofs,
                                             input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{ofs, 3'b000} +: 8];
      h = ofs[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  fmt_load = {{24{b[7]}}, b};
         3'b100:  fmt_load = {24'd0, b};
         3'b001:  fmt_load = {{16{h[15]}}, h};
         3'b101:  fmt_load = {16'd0, h};
         default: fmt_load = w;
      endcase
   endfunction

   assign is_full   = (state_q == ST_FULL);
   assign mem_ready = (state_q != ST_WAIT_LOAD);
   assign accept    = mem_valid && mem_ready;

   always_comb begin
      state_d   = state_q;
      rd_d      = rd_q;
      reg_wen_d = reg_wen_q;
      data_d    = data_q;
      funct3_d  = funct3_q;
      ofs_d     = ofs_q;
      count_d   = count_q;
      if (is_full) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case (state_q)
         ST_WAIT_LOAD: begin
            if (dmem_rvalid) begin
               data_d  = fmt_load(funct3_q, ofs_q, dmem_rdata);
               state_d = ST_FULL;
            end
         end
         default: begin
            if (accept) begin
               rd_d      = mem_rd;
               reg_wen_d = mem_reg_wen;
               funct3_d  = mem_funct3;
               ofs_d     = mem_alu_result[1:0];
               if (mem_wb_sel == 2'd1) begin
                  state_d = ST_WAIT_LOAD;
               end else begin
                  state_d = ST_FULL;
                  data_d  = (mem_wb_sel == 2'd2) ? (mem_pc + 32'd4) : mem_alu_result;
               end
            end else begin
               state_d = ST_EMPTY;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_EMPTY;
         rd_q      <= 5'd0;
         reg_wen_q <= 1'b0;
         data_q    <= 32'd0;
         funct3_q  <= 3'd0;
         ofs_q     <= 2'd0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         rd_q      <= rd_d;
         reg_wen_q <= reg_wen_d;
         data_q    <= data_d;
         funct3_q  <= funct3_d;
         ofs_q     <= ofs_d;
         count_q   <= count_d;
      end
   end

   // Write port is visible only while the held instruction retires.
   assign wb_write_enable = is_full && reg_wen_q && (rd_q != 5'd0);
   assign wb_addr_rd      = is_full ? {27'd0, rd_q} : 32'd0;
   assign wb_data_rd      = is_full ? data_q : 32'd0;
   assign wb_retire       = is_full;
   assign wb_retire_count = count_q;
   assign dbg_state       = state_q;

`ifdef WB_BYPASS_EN
   assign wb_fwd_valid = wb_write_enable;
   assign wb_fwd_rd    = is_full ? rd_q : 5'd0;
   assign wb_fwd_data  = wb_data_rd;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, hand sequences, and randomized loads/ALU ops
// checked against an arithmetic reference model.
module tb_writeback_stage;

  localparam int CNT_W = 4;

  logic             clock;
  logic             reset_n;
  logic             mem_valid;
  logic             mem_ready;
  logic [4:0]       mem_rd;
  logic             mem_reg_wen;
  logic [1:0]       mem_wb_sel;
  logic [31:0]      mem_alu_result;
  logic [31:0]      mem_pc;
  logic [2:0]       mem_funct3;
  logic             dmem_rvalid;
  logic [31:0]      dmem_rdata;
  logic [31:0]      wb_addr_rd;
  logic [31:0]      wb_data_rd;
  logic             wb_write_enable;
  logic             wb_retire;
  logic [CNT_W-1:0] wb_retire_count;
  logic [1:0]       dbg_state;
`ifdef WB_BYPASS_EN
  logic             wb_fwd_valid;
  logic [4:0]       wb_fwd_rd;
  logic [31:0]      wb_fwd_data;
`endif

  int checks;
  int errors;
  int model_count;
  logic [31:0] exp_q[$];

  writeback_stage #(.CNT_W(CNT_W)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_rd          (mem_rd),
    .mem_reg_wen     (mem_reg_wen),
    .mem_wb_sel      (mem_wb_sel),
    .mem_alu_result  (mem_alu_result),
    .mem_pc          (mem_pc),
    .mem_funct3      (mem_funct3),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata),
    .wb_addr_rd      (wb_addr_rd),
    .wb_data_rd      (wb_data_rd),
    .wb_write_enable (wb_write_enable),
    .wb_retire       (wb_retire),
    .wb_retire_count (wb_retire_count),
`ifdef WB_BYPASS_EN
    .wb_fwd_valid    (wb_fwd_valid),
    .wb_fwd_rd       (wb_fwd_rd),
    .wb_fwd_data     (wb_fwd_data),
`endif
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [1:0] sel, input logic [2:0] f3,
                                             input logic [31:0] alu, input logic [31:0] pc,
                                             input logic [31:0] rdata);
    longint unsigned ofs, val;
    if (sel == 2'd2) return pc + 32'd4;
    if (sel != 2'd1) return alu;
    ofs = longint'(alu % 4);
    case (f3)
      3'b000, 3'b100: begin
        val = (longint'(rdata) / (longint'(1) << (8 * ofs))) % 256;
        if (f3 == 3'b000 && val >= 128) val = val + 64'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        val = (longint'(rdata) / (longint'(1) << (16 * (ofs / 2)))) % 65536;
        if (f3 == 3'b001 && val >= 32768) val = val + 64'hFFFF_0000;
      end
      default: val = longint'(rdata);
    endcase
    return val[31:0];
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Checks the write port for one cycle; full means an instruction is retiring now.
  task automatic check_wb(input string name, input logic full, input logic [4:0] rd,
                          input logic wen, input logic [31:0] data);
    logic we;
    we = full && wen && (rd != 5'd0);
    chk({name, " we"}, {31'd0, wb_write_enable}, {31'd0, we});
    chk({name, " addr"}, wb_addr_rd, full ? {27'd0, rd} : 32'd0);
    chk({name, " data"}, wb_data_rd, full ? data : 32'd0);
    chk({name, " retire"}, {31'd0, wb_retire}, {31'd0, full});
    chk({name, " count"}, {{(32-CNT_W){1'b0}}, wb_retire_count}, model_count % (1 << CNT_W));
`ifdef WB_BYPASS_EN
    chk({name, " fwd_valid"}, {31'd0, wb_fwd_valid}, {31'd0, we});
    chk({name, " fwd_rd"}, {27'd0, wb_fwd_rd}, full ? {27'd0, rd} : 32'd0);
    chk({name, " fwd_data"}, wb_fwd_data, full ? data : 32'd0);
`endif
    if (full) model_count++;
  endtask

  // ---------------- driver ----------------
  // Entered and left #1 after a posedge with the stage empty.
  task automatic do_txn(input string name, input logic [1:0] sel, input logic [2:0] f3,
                        input logic [4:0] rd, input logic wen, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [31:0] rdata, input int lat);
    logic [31:0] exp;
    exp_q.push_back(ref_result(sel, f3, alu, pc, rdata));
    chk({name, " ready_in"}, {31'd0, mem_ready}, 32'd1);
    mem_valid = 1'b1; mem_wb_sel = sel; mem_funct3 = f3; mem_rd = rd;
    mem_reg_wen = wen; mem_alu_result = alu; mem_pc = pc;
    @(posedge clock); #1;
    mem_valid = 1'b0;
    mem_alu_result = $urandom; mem_pc = $urandom;
    if (sel == 2'd1) begin
      for (int i = 0; i < lat; i++) begin
        chk({name, " ready_low"}, {31'd0, mem_ready}, 32'd0);
        check_wb({name, " wait"}, 1'b0, rd, wen, 32'd0);
        if (i == lat - 1) begin
          dmem_rvalid = 1'b1;
          dmem_rdata = rdata;
        end
        @(posedge clock); #1;
        dmem_rvalid = 1'b0;
        dmem_rdata = $urandom;
      end
    end
    exp = exp_q.pop_front();
    check_wb({name, " strobe"}, 1'b1, rd, wen, exp);
    @(posedge clock); #1;
    check_wb({name, " after"}, 1'b0, rd, wen, 32'd0);
    chk({name, " ready_out"}, {31'd0, mem_ready}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  initial begin
    checks = 0; errors = 0; model_count = 0;
    vecs[0]  = '{"alu_rd5",  2'd0, 3'b000, 5'd5, 1'b1, 32'h1234_5678, 32'h0,         32'h0,         1, 32'h1234_5678};
    vecs[1]  = '{"lb_1003",  2'd1, 3'b000, 5'd3, 1'b1, 32'h0000_1003, 32'h0,         32'h80AB_CDEF, 4, 32'hFFFF_FF80};
    vecs[2]  = '{"lbu_1003", 2'd1, 3'b100, 5'd3, 1'b1, 32'h0000_1003, 32'h0,         32'h80AB_CDEF, 4, 32'h0000_0080};
    vecs[3]  = '{"lh_2002",  2'd1, 3'b001, 5'd4, 1'b1, 32'h0000_2002, 32'h0,         32'h8001_7FFF, 2, 32'hFFFF_8001};
    vecs[4]  = '{"lhu_2002", 2'd1, 3'b101, 5'd4, 1'b1, 32'h0000_2002, 32'h0,         32'h8001_7FFF, 1, 32'h0000_8001};
    vecs[5]  = '{"lw_2002",  2'd1, 3'b010, 5'd6, 1'b1, 32'h0000_2002, 32'h0,         32'h8001_7FFF, 3, 32'h8001_7FFF};
    vecs[6]  = '{"alu_rd0",  2'd0, 3'b000, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h0,         32'h0,         1, 32'hDEAD_BEEF};
    vecs[7]  = '{"jal_wrap", 2'd2, 3'b000, 5'd1, 1'b1, 32'h5555_0000, 32'hFFFF_FFFC, 32'h0,         1, 32'h0000_0000};
    vecs[8]  = '{"sel3",     2'd3, 3'b000, 5'd9, 1'b1, 32'hA5A5_A5A5, 32'h0000_1000, 32'h0,         1, 32'hA5A5_A5A5};
    vecs[9]  = '{"lh_odd",   2'd1, 3'b001, 5'd8, 1'b1, 32'h0000_2001, 32'h0,         32'h1234_F00D, 1, 32'hFFFF_F00D};
    vecs[10] = '{"ld_f3_3",  2'd1, 3'b011, 5'd7, 1'b1, 32'h0000_0002, 32'h0,         32'hCAFE_F00D, 2, 32'hCAFE_F00D};
    vecs[11] = '{"nowen",    2'd0, 3'b000, 5'd7, 1'b0, 32'h0BAD_0BAD, 32'h0,         32'h0,         1, 32'h0BAD_0BAD};

    reset_n = 1'b0; mem_valid = 1'b0; mem_rd = '0; mem_reg_wen = 1'b0; mem_wb_sel = '0;
    mem_alu_result = '0; mem_pc = '0; mem_funct3 = '0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset ready", {31'd0, mem_ready}, 32'd1);
    check_wb("reset", 1'b0, 5'd0, 1'b0, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Table entries: the bench's own expected value must agree with the model too.
    foreach (vecs[i]) begin
      chk({vecs[i].name, " model"},
          ref_result(vecs[i].sel, vecs[i].f3, vecs[i].alu, vecs[i].pc, vecs[i].rdata),
          vecs[i].exp_data);
      do_txn(vecs[i].name, vecs[i].sel, vecs[i].f3, vecs[i].rd, vecs[i].wen,
             vecs[i].alu, vecs[i].pc, vecs[i].rdata, vecs[i].lat);
    end

    // rvalid while empty must be ignored
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    dmem_rvalid = 1'b0;
    check_wb("rvalid_empty", 1'b0, 5'd0, 1'b0, 32'd0);

    // Three back-to-back ALU ops, with a stray rvalid while full
    mem_valid = 1'b1; mem_wb_sel = 2'd0; mem_reg_wen = 1'b1;
    mem_rd = 5'd10; mem_alu_result = 32'h0000_0A0A;
    @(posedge clock); #1;
    mem_rd = 5'd11; mem_alu_result = 32'h0000_0B0B; dmem_rvalid = 1'b1;
    chk("b2b ready1", {31'd0, mem_ready}, 32'd1);
    check_wb("b2b op1", 1'b1, 5'd10, 1'b1, 32'h0000_0A0A);
    @(posedge clock); #1;
    mem_rd = 5'd12; mem_alu_result = 32'h0000_0C0C; dmem_rvalid = 1'b0;
    chk("b2b ready2", {31'd0, mem_ready}, 32'd1);
    check_wb("b2b op2", 1'b1, 5'd11, 1'b1, 32'h0000_0B0B);
    @(posedge clock); #1;
    mem_valid = 1'b0;
    check_wb("b2b op3", 1'b1, 5'd12, 1'b1, 32'h0000_0C0C);
    @(posedge clock); #1;
    check_wb("b2b idle", 1'b0, 5'd0, 1'b0, 32'd0);

    // Randomized transactions (counter wraps at 2^CNT_W)
    for (int n = 0; n < 60; n++) begin
      do_txn("rand", 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom),
             1'($urandom), $urandom, $urandom, $urandom, $urandom_range(1, 5));
    end

    // Async reset while waiting on load data drops the load and clears the count
    mem_valid = 1'b1; mem_wb_sel = 2'd1; mem_funct3 = 3'b010; mem_rd = 5'd2;
    mem_reg_wen = 1'b1; mem_alu_result = 32'h100;
    @(posedge clock); #1;
    mem_valid = 1'b0;
    chk("rst_load ready", {31'd0, mem_ready}, 32'd0);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    model_count = 0;
    chk("rst_load ready_async", {31'd0, mem_ready}, 32'd1);
    check_wb("rst_load async", 1'b0, 5'd0, 1'b0, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF;
    @(posedge clock); #1;
    dmem_rvalid = 1'b0;
    check_wb("rst_load post", 1'b0, 5'd0, 1'b0, 32'd0);
    @(posedge clock); #1;
    check_wb("rst_load post2", 1'b0, 5'd0, 1'b0, 32'd0);
    do_txn("post_reset", 2'd0, 3'b000, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
